// File: rtl/riscv_multi_core.sv
// Multicycle RV32 integer core with req/ack instruction and data ports; MUL_EN adds the mul instruction.
// Latency: ALU 4, load 5, store 4, branch/jal 3 cycles minimum; each memory state waits for its ack.
module riscv_multi_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] EOF_WORD = 32'h1111_1111
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_ack,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] clock_count
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111,
                         OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_BR = 7'b1100011,
                         OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
  state_t r_state, w_next;

  logic [31:0]      r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
  logic [31:0]      r_regs [NUM_REGS];
  logic             r_done, r_error;
  logic [CNT_W-1:0] r_cnt;

  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
  logic [31:0] w_rs1_val, w_rs2_val, w_alu, w_rf_wdata;
  logic        w_is_add, w_is_sub, w_is_mul, w_is_addi, w_is_slli, w_is_lui;
  logic        w_is_lw, w_is_sw, w_is_br, w_is_jal, w_legal, w_taken, w_rf_we;

  assign w_op  = r_ir[6:0];
  assign w_rd  = r_ir[11:7];
  assign w_f3  = r_ir[14:12];
  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_f7  = r_ir[31:25];

  assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
  assign w_imm_u = {r_ir[31:12], 12'b0};

  assign w_is_add  = (w_op == OP_R) && (w_f3 == 3'b000) && (w_f7 == 7'b0000000);
  assign w_is_sub  = (w_op == OP_R) && (w_f3 == 3'b000) && (w_f7 == 7'b0100000);
`ifdef MUL_EN
  assign w_is_mul  = (w_op == OP_R) && (w_f3 == 3'b000) && (w_f7 == 7'b0000001);
`else
  assign w_is_mul  = 1'b0;
`endif
  assign w_is_addi = (w_op == OP_I) && (w_f3 == 3'b000);
  assign w_is_slli = (w_op == OP_I) && (w_f3 == 3'b001) && (w_f7 == 7'b0000000);
  assign w_is_lui  = (w_op == OP_LUI);
  assign w_is_lw   = (w_op == OP_LD) && (w_f3 == 3'b010);
  assign w_is_sw   = (w_op == OP_ST) && (w_f3 == 3'b010);
  assign w_is_br   = (w_op == OP_BR) && (w_f3 inside {3'b000, 3'b001, 3'b100, 3'b101});
  assign w_is_jal  = (w_op == OP_JAL);
  assign w_legal   = w_is_add | w_is_sub | w_is_mul | w_is_addi | w_is_slli | w_is_lui |
                     w_is_lw | w_is_sw | w_is_br | w_is_jal;

  // x0 and indices beyond the implemented file read as zero
  assign w_rs1_val = (w_rs1 == 5'd0 || int'(w_rs1) >= NUM_REGS) ? 32'd0 : r_regs[w_rs1[IDX_W-1:0]];
  assign w_rs2_val = (w_rs2 == 5'd0 || int'(w_rs2) >= NUM_REGS) ? 32'd0 : r_regs[w_rs2[IDX_W-1:0]];

  always_comb begin
    w_alu = r_a + r_b;
    if (w_is_sub)                 w_alu = r_a - r_b;
    else if (w_is_addi || w_is_lw) w_alu = r_a + w_imm_i;
    else if (w_is_sw)             w_alu = r_a + w_imm_s;
    else if (w_is_slli)           w_alu = r_a << r_ir[24:20];
    else if (w_is_lui)            w_alu = w_imm_u;
`ifdef MUL_EN
    else if (w_is_mul)            w_alu = r_a * r_b;
`endif
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000:  w_taken = (r_a == r_b);
      3'b001:  w_taken = (r_a != r_b);
      3'b100:  w_taken = ($signed(r_a) <  $signed(r_b));
      3'b101:  w_taken = ($signed(r_a) >= $signed(r_b));
      default: w_taken = 1'b0;
    endcase
  end

  // jal links in EX; everything else writes back in WB
  assign w_rf_we    = ((r_state == S_WB) || ((r_state == S_EX) && w_is_jal)) &&
                      (w_rd != 5'd0) && (int'(w_rd) < NUM_REGS);
  assign w_rf_wdata = (r_state == S_WB) ? (w_is_lw ? r_mdr : r_aluout) : r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IF;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IF:  if (imem_ack) w_next = S_ID;
      S_ID:  w_next = (r_ir == EOF_WORD) ? S_HALT : S_EX;
      S_EX: begin
        if (!w_legal)                w_next = S_HALT;
        else if (w_is_lw || w_is_sw) w_next = S_MEM;
        else if (w_is_br || w_is_jal) w_next = S_IF;
        else                         w_next = S_WB;
      end
      S_MEM: if (dmem_ack) w_next = w_is_lw ? S_WB : S_IF;
      S_WB:  w_next = S_IF;
      default: w_next = S_HALT;
    endcase
  end

  // imem_req also drops combinationally while reset is held
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    case (r_state)
      S_IF:  imem_req = rst_n;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_sw;
      end
      default: ;
    endcase
  end

  assign imem_addr   = r_pc;
  assign dmem_addr   = {r_aluout[31:2], 2'b00};
  assign dmem_wdata  = r_b;
  assign done        = r_done;
  assign error       = r_error;
  assign clock_count = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_cnt    <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (r_state != S_HALT && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
      if (w_rf_we) r_regs[w_rd[IDX_W-1:0]] <= w_rf_wdata;
      case (r_state)
        S_IF: if (imem_ack) begin
          r_ir <= imem_rdata;
          r_pc <= r_pc + 32'd4;
        end
        S_ID: begin
          if (r_ir == EOF_WORD) r_done <= 1'b1;
          r_a      <= w_rs1_val;
          r_b      <= w_rs2_val;
          r_aluout <= r_pc - 32'd4 + (w_is_jal ? w_imm_j : w_imm_b);
        end
        S_EX: begin
          if (!w_legal)                 r_error  <= 1'b1;
          else if (w_is_br)             begin if (w_taken) r_pc <= r_aluout; end
          else if (w_is_jal)            r_pc     <= r_aluout;
          else                          r_aluout <= w_alu;
        end
        S_MEM: if (dmem_ack && !w_is_sw) r_mdr <= dmem_rdata;
        default: ;
      endcase
    end
  end
endmodule
